framebuffer_readback_tx: RTL and testbench

//  Readback path for the LED-matrix framebuffer: on request, reads one 64-pixel row
//  of RGB565 words over the framebuffer's 16-bit read port and transmits it as

---
 rtl/framebuffer_readback_tx_pkg.sv | 38 +++
 rtl/framebuffer_readback_tx_uart_tx.sv | 68 ++++++
 rtl/framebuffer_readback_tx.sv | 184 ++++++++++++++++++
 tb/tb_framebuffer_readback_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_readback_tx_pkg.sv
// Shared constants and types for the framebuffer readback transmitter.
//   ASCII framing constants, default geometry, frame FSM state encoding,
//   and the nibble-to-uppercase-hex helper.
package framebuffer_readback_tx_pkg;

    localparam int unsigned FB_ROW_WIDTH  = 5;
    localparam int unsigned FB_COL_WIDTH  = 6;
    localparam int unsigned FB_ADDR_WIDTH = FB_ROW_WIDTH + FB_COL_WIDTH;

    localparam logic [7:0] ASCII_L          = 8'h4C;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_HEX_BASE   = 8'h41;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_L,
        S_HDR_D1,
        S_HDR_D0,
        S_FETCH,
        S_WAIT,
        S_NIB0,
        S_NIB1,
        S_NIB2,
        S_NIB3,
        S_EOL,
        S_DONE
    } fb_state_e;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_DIGIT_BASE + 8'(nib);
        end
        return ASCII_HEX_BASE + 8'(nib - 4'd10);
    endfunction

endpackage

// File: rtl/framebuffer_readback_tx_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte handshake.
//   clk_in, reset      : clock, synchronous active-high reset
//   tx_valid, tx_byte  : byte offered by the frame FSM
//   tx_ready           : high when a byte can be accepted; rises on the final
//                        stop-bit cycle so bytes can be sent back to back
//   tx_out             : serial line, idles high
module uart_tx_8n1 #(
    parameter int unsigned CLK_DIV_WIDTH = 8,
    parameter int unsigned CLK_DIV_COUNT = 115
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       tx_out
);

    localparam logic [CLK_DIV_WIDTH-1:0] BAUD_RELOAD = CLK_DIV_WIDTH'(CLK_DIV_COUNT - 1);
    localparam logic [3:0]               STOP_BIT    = 4'd9;
    localparam logic [3:0]               LAST_DATA   = 4'd8;

    logic                     in_flight;
    logic [3:0]               bit_idx;
    logic [7:0]               shift_q;
    logic [CLK_DIV_WIDTH-1:0] baud_cnt;

    // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge clk_in) begin
        if (reset) begin
            in_flight <= 1'b0;
            bit_idx   <= 4'd0;
            shift_q   <= 8'h00;
            baud_cnt  <= '0;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            in_flight <= 1'b1;
            shift_q   <= tx_byte;
            bit_idx   <= 4'd0;
            baud_cnt  <= BAUD_RELOAD;
            tx_out    <= 1'b0;
            tx_ready  <= 1'b0;
        end else if (in_flight) begin
            if (baud_cnt == '0) begin
                if (bit_idx == STOP_BIT) begin
                    in_flight <= 1'b0;
                end else begin
                    bit_idx  <= bit_idx + 4'd1;
                    baud_cnt <= BAUD_RELOAD;
                    if (bit_idx == LAST_DATA) begin
                        tx_out <= 1'b1;
                    end else begin
                        tx_out  <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt - CLK_DIV_WIDTH'(1);
                // Ready one cycle early so it is visible on the last stop cycle
                if (bit_idx == STOP_BIT && baud_cnt == CLK_DIV_WIDTH'(1)) begin
                    tx_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/framebuffer_readback_tx.sv
// Reads one framebuffer row and sends it as "Lrr" + 256 hex chars + LF over UART.
//   clk_in, reset          : clock, synchronous active-high reset
//   start, row_in          : one-cycle request and row, sampled in IDLE
//   busy, done, error      : frame in progress / frame complete / bad row pulses
//   ram_address            : {row, col} read address
//   ram_clk_enable         : read strobe, data returns on ram_data_in next cycle
//   ram_data_in            : RGB565 pixel
//   tx_out                 : UART line
module framebuffer_readback_tx
    import framebuffer_readback_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV_WIDTH = 8,
    parameter int unsigned CLK_DIV_COUNT = 115,
    parameter int unsigned ROW_WIDTH     = FB_ROW_WIDTH,
    parameter int unsigned COL_WIDTH     = FB_COL_WIDTH,
    parameter int unsigned ROWS          = 32
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROW_WIDTH-1:0]           row_in,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [ROW_WIDTH+COL_WIDTH-1:0] ram_address,
    output logic                           ram_clk_enable,
    input  logic [15:0]                    ram_data_in,
    output logic                           tx_out
);

    localparam logic [COL_WIDTH-1:0] COL_LAST = '1;

    fb_state_e                      state, next_state;
    logic [ROW_WIDTH-1:0]           row_q, row_d;
    logic [COL_WIDTH-1:0]           col_q, col_d;
    logic [15:0]                    pixel_q, pixel_d;
    logic                           busy_d, done_d, error_d, ram_en_d;
    logic [ROW_WIDTH+COL_WIDTH-1:0] ram_addr_d;
    logic                           tx_valid_c;
    logic [7:0]                     tx_byte_c;
    logic                           tx_ready;
    logic [7:0]                     row_ext_c;

    assign row_ext_c = 8'(row_q);

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state          <= S_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            pixel_q        <= 16'h0000;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            ram_clk_enable <= 1'b0;
            ram_address    <= '0;
        end else begin
            state          <= next_state;
            row_q          <= row_d;
            col_q          <= col_d;
            pixel_q        <= pixel_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
            ram_clk_enable <= ram_en_d;
            ram_address    <= ram_addr_d;
        end
    end

    // Next state, next register values and the byte offered to the UART
    always_comb begin
        next_state = state;
        row_d      = row_q;
        col_d      = col_q;
        pixel_d    = pixel_q;
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = 1'b0;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_address;
        tx_valid_c = 1'b0;
        tx_byte_c  = 8'h00;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (32'(row_in) < ROWS) begin
                        row_d      = row_in;
                        col_d      = '0;
                        busy_d     = 1'b1;
                        next_state = S_HDR_L;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_HDR_L: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = ASCII_L;
                if (tx_ready) next_state = S_HDR_D1;
            end
            S_HDR_D1: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = ASCII_DIGIT_BASE + row_ext_c / 8'd10;
                if (tx_ready) next_state = S_HDR_D0;
            end
            S_HDR_D0: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = ASCII_DIGIT_BASE + row_ext_c % 8'd10;
                if (tx_ready) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = {row_q, col_q};
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                pixel_d    = ram_data_in;
                next_state = S_NIB0;
            end
            S_NIB0: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = hex_char(pixel_q[15:12]);
                if (tx_ready) next_state = S_NIB1;
            end
            S_NIB1: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = hex_char(pixel_q[11:8]);
                if (tx_ready) next_state = S_NIB2;
            end
            S_NIB2: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = hex_char(pixel_q[7:4]);
                if (tx_ready) next_state = S_NIB3;
            end
            S_NIB3: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = hex_char(pixel_q[3:0]);
                if (tx_ready) begin
                    if (col_q == COL_LAST) begin
                        next_state = S_EOL;
                    end else begin
                        col_d      = col_q + COL_WIDTH'(1);
                        ram_en_d   = 1'b1;
                        ram_addr_d = {row_q, col_d};
                        next_state = S_FETCH;
                    end
                end
            end
            S_EOL: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = ASCII_LF;
                if (tx_ready) next_state = S_DONE;
            end
            S_DONE: begin
                // Ready returns on the LF stop bit's last cycle
                if (tx_ready) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    uart_tx_8n1 #(
        .CLK_DIV_WIDTH(CLK_DIV_WIDTH),
        .CLK_DIV_COUNT(CLK_DIV_COUNT)
    ) u_uart (
        .clk_in  (clk_in),
        .reset   (reset),
        .tx_valid(tx_valid_c),
        .tx_byte (tx_byte_c),
        .tx_ready(tx_ready),
        .tx_out  (tx_out)
    );

endmodule

// File: tb/tb_framebuffer_readback_tx.sv
// Bench for framebuffer_readback_tx: UART decoder, RAM model, frame vectors.
module tb_framebuffer_readback_tx;

    localparam int unsigned DIV      = 4;
    localparam int unsigned BYTE_CYC = 10 * DIV;

    logic        clk_root_logic = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  row_in;
    logic        busy, done, error;
    logic [10:0] ram_address;
    logic        ram_clk_enable;
    logic [15:0] ram_data_in;
    logic        tx_out;

    int n_cmp = 0;
    int n_bad = 0;

    int ram_mode = 0;

    // Observation state, cleared per scenario
    logic [7:0] rx_q[$];
    int  done_cnt, err_cnt, ram_cnt, busy_cnt, low_cnt, bit_err, gap_err;
    int  cyc = 0;
    bit  rx_on = 1'b0;
    int  rx_c = 0;
    logic rx_bit = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    bit  rx_have_last = 1'b0;
    int  rx_last_start = 0;
    logic busy_at_start;

    always #5 clk_root_logic = ~clk_root_logic;

    // Rows are limited to 24 so the reject path is reachable with a 5-bit row_in
    framebuffer_readback_tx #(
        .CLK_DIV_WIDTH(8),
        .CLK_DIV_COUNT(DIV),
        .ROW_WIDTH(5),
        .COL_WIDTH(6),
        .ROWS(24)
    ) dut (
        .clk_in        (clk_root_logic),
        .reset         (reset),
        .start         (start),
        .row_in        (row_in),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .ram_address   (ram_address),
        .ram_clk_enable(ram_clk_enable),
        .ram_data_in   (ram_data_in),
        .tx_out        (tx_out)
    );

    function automatic logic [15:0] pixel_of(input int mode, input logic [4:0] r, input logic [5:0] c);
        return (mode == 0) ? {r, c, 5'h00} : 16'hF81F;
    endfunction

    always @(posedge clk_root_logic) begin
        if (ram_clk_enable) ram_data_in <= pixel_of(ram_mode, ram_address[10:6], ram_address[5:0]);
    end

    // Expected byte idx of a frame for a given row/pattern
    function automatic logic [7:0] exp_byte(input int row, input int mode, input int idx);
        logic [15:0] px;
        int col, nib, v;
        if (idx == 0) return 8'h4C;
        if (idx == 1) return 8'(48 + row / 10);
        if (idx == 2) return 8'(48 + row % 10);
        if (idx == 259) return 8'h0A;
        col = (idx - 3) / 4;
        nib = (idx - 3) % 4;
        px  = pixel_of(mode, 5'(row), 6'(col));
        v   = int'((px >> (12 - 4 * nib)) & 16'h000F);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    // UART decoder plus event counters, sampled on the falling edge
    always @(negedge clk_root_logic) begin
        cyc = cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (error) err_cnt = err_cnt + 1;
        if (ram_clk_enable) ram_cnt = ram_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (!tx_out) low_cnt = low_cnt + 1;
        if (reset) begin
            rx_on = 1'b0;
        end else begin
            if (!rx_on && tx_out == 1'b0) begin
                rx_on = 1'b1;
                rx_c  = 0;
                if (rx_have_last && (cyc - rx_last_start) != BYTE_CYC) gap_err = gap_err + 1;
                rx_have_last  = 1'b1;
                rx_last_start = cyc;
            end
            if (rx_on) begin
                int k;
                k = rx_c / DIV;
                if (rx_c % DIV == 0) begin
                    rx_bit = tx_out;
                    if (k >= 1 && k <= 8) rx_byte[k-1] = tx_out;
                    if (k == 9 && tx_out != 1'b1) bit_err = bit_err + 1;
                end else if (tx_out != rx_bit) begin
                    bit_err = bit_err + 1;
                end
                if (rx_c == BYTE_CYC - 1) begin
                    rx_q.push_back(rx_byte);
                    rx_on = 1'b0;
                end
                rx_c = rx_c + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        rx_q.delete();
        done_cnt = 0; err_cnt = 0; ram_cnt = 0; busy_cnt = 0; low_cnt = 0;
        bit_err = 0; gap_err = 0;
        rx_have_last = 1'b0;
    endtask

    function automatic logic [7:0] q_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'h00;
    endfunction

    function automatic int stream_mism(input int row, input int mode);
        int m = 0;
        for (int i = 0; i < rx_q.size() && i < 260; i++) begin
            if (rx_q[i] !== exp_byte(row, mode, i)) m++;
        end
        return m;
    endfunction

    task automatic pulse_start(input logic [4:0] r);
        @(negedge clk_root_logic);
        start  = 1'b1;
        row_in = r;
        @(negedge clk_root_logic);
        start  = 1'b0;
        busy_at_start = busy;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(negedge clk_root_logic);
            t++;
        end
        repeat (5) @(negedge clk_root_logic);
    endtask

    task automatic run_frame(input logic [4:0] r, input int mode, input int expect_err);
        ram_mode = mode;
        clear_stats();
        pulse_start(r);
        if (expect_err != 0) repeat (60) @(negedge clk_root_logic);
        else wait_done(15000);
    endtask

    typedef struct {
        logic [4:0]  row;
        int          mode;
        int          exp_err;
        int          exp_len;
        logic [23:0] hdr;
        logic [31:0] first_px;
        logic [31:0] last_px;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{5'd17, 0, 0, 260, "L17", "8800", "8FE0"};
        vecs[1] = '{5'd24, 0, 1, 0,   "---", "----", "----"};
        vecs[2] = '{5'd3,  1, 0, 260, "L03", "F81F", "F81F"};
        vecs[3] = '{5'd31, 0, 1, 0,   "---", "----", "----"};
        vecs[4] = '{5'd23, 0, 0, 260, "L23", "B800", "BFE0"};

        reset = 1'b1; start = 1'b0; row_in = 5'd0; ram_data_in = 16'h0000;
        clear_stats();
        repeat (3) @(negedge clk_root_logic);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_ram_en", 32'(ram_clk_enable), 32'd0);
        check("rst_tx", 32'(tx_out), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk_root_logic);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].row, vecs[i].mode, vecs[i].exp_err);
            check($sformatf("v%0d_err", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_busy_start", i), 32'(busy_at_start), 32'(vecs[i].exp_err == 0));
            check($sformatf("v%0d_done", i), 32'(done_cnt), 32'(vecs[i].exp_err == 0));
            check($sformatf("v%0d_len", i), 32'(rx_q.size()), 32'(vecs[i].exp_len));
            check($sformatf("v%0d_ram_reads", i), 32'(ram_cnt), (vecs[i].exp_err != 0) ? 32'd0 : 32'd64);
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            if (vecs[i].exp_err == 0) begin
                check($sformatf("v%0d_hdr", i), {8'h00, q_at(0), q_at(1), q_at(2)}, {8'h00, vecs[i].hdr});
                check($sformatf("v%0d_first_px", i), {q_at(3), q_at(4), q_at(5), q_at(6)}, vecs[i].first_px);
                check($sformatf("v%0d_last_px", i), {q_at(255), q_at(256), q_at(257), q_at(258)}, vecs[i].last_px);
                check($sformatf("v%0d_lf", i), 32'(q_at(259)), 32'h0A);
                check($sformatf("v%0d_stream", i), 32'(stream_mism(int'(vecs[i].row), vecs[i].mode)), 32'd0);
                check($sformatf("v%0d_bit_timing", i), 32'(bit_err), 32'd0);
                check($sformatf("v%0d_byte_gap", i), 32'(gap_err), 32'd0);
            end else begin
                check($sformatf("v%0d_tx_idle", i), 32'(low_cnt), 32'd0);
                check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'd0);
            end
        end

        // Start while busy: row 9 frame must be untouched, no row 5 frame
        ram_mode = 0;
        clear_stats();
        pulse_start(5'd9);
        repeat (500) @(negedge clk_root_logic);
        pulse_start(5'd5);
        wait_done(15000);
        repeat (300) @(negedge clk_root_logic);
        check("mid_err", 32'(err_cnt), 32'd0);
        check("mid_done", 32'(done_cnt), 32'd1);
        check("mid_len", 32'(rx_q.size()), 32'd260);
        check("mid_stream", 32'(stream_mism(9, 0)), 32'd0);
        check("mid_ram_reads", 32'(ram_cnt), 32'd64);
        check("mid_busy", 32'(busy), 32'd0);

        // Reset during byte 100 aborts the frame with no done
        clear_stats();
        pulse_start(5'd17);
        begin
            int t = 0;
            while (rx_q.size() < 99 && t < 6000) begin
                @(negedge clk_root_logic);
                t++;
            end
        end
        check("rst_mid_reached", 32'(rx_q.size()), 32'd99);
        repeat (10) @(negedge clk_root_logic);
        reset = 1'b1;
        @(negedge clk_root_logic);
        check("rst_mid_tx", 32'(tx_out), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        done_cnt = 0;
        low_cnt  = 0;
        repeat (300) @(negedge clk_root_logic);
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check("rst_mid_tx_idle", 32'(low_cnt), 32'd0);

        run_frame(5'd0, 0, 0);
        check("post_rst_hdr", {8'h00, q_at(0), q_at(1), q_at(2)}, {8'h00, 24'("L00")});
        check("post_rst_first_px", {q_at(3), q_at(4), q_at(5), q_at(6)}, 32'("0000"));
        check("post_rst_len", 32'(rx_q.size()), 32'd260);
        check("post_rst_stream", 32'(stream_mism(0, 0)), 32'd0);
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_bit_timing", 32'(bit_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
